stob_counter: RTL
=================

// Module: stob_counter
// PURPOSE
//  Stochastic-to-binary converter. Sits directly downstream of the ReSC core
//  inside the ReSC wrapper and consumes the core's serial output bitstream.
//  On start, counts the ones in a STREAM_LEN-bit stream and returns a
//  BIN_WIDTH-bit binary result with a one-cycle done pulse. It is the stage
//  that produces the wrapper's y_bin/done pair.
// PARAMETERS
//  BIN_WIDTH   10    width of y_bin (result)
//  STREAM_LEN  1024  bitstream length in clocks; even, 2 <= STREAM_LEN <= 2**BIN_WIDTH
// PORTS
//  clk     in   1          single clock, all logic on posedge
//  reset   in   1          synchronous, active-high
//  start   in   1          level; sampled only in IDLE
//  bit_in  in   1          stochastic bit from ReSC core, sampled every COUNT cycle
//  y_bin   out  BIN_WIDTH  registered result; holds until next completion
//  done    out  1          one-cycle pulse, same edge y_bin updates
//  busy    out  1          high while in COUNT
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, y_bin=0, done=0, busy=0, counters=0.
//    Reset mid-COUNT aborts: no done, y_bin=0, partial count discarded.
//  - FSM: IDLE -> COUNT when start=1 at an edge (counters cleared that edge).
//    COUNT: each edge samples bit_in, increments cycle counter
//    (clog2(STREAM_LEN) bits) and updates the ones accumulator
//    (BIN_WIDTH+1 bits, so STREAM_LEN ones never wrap).
//    At the edge sampling bit number STREAM_LEN (cycle counter ==
//    STREAM_LEN-1): y_bin <= final result including that bit, done <= 1,
//    state -> IDLE.
//  - done is high exactly one cycle; busy low in that cycle.
//  - Latency: start sampled at edge k -> bits sampled at edges k+1..k+STREAM_LEN
//    -> done/y_bin valid after edge k+STREAM_LEN.
//  - start held high continuously: restart on the edge after done; period is
//    STREAM_LEN+1 clocks. start changes during COUNT are ignored.
//  - Result (unipolar): y_bin = min(ones, 2**BIN_WIDTH-1); all-ones saturates.
//  - bit_in X/Z is not checked; the upstream core drives it every cycle.
// CONFIGURATION
//  STOB_BIPOLAR_EN defined: accumulator is an up/down counter (+1 on a 1,
//  -1 on a 0), signed BIN_WIDTH+2 bits, cleared to 0 at start.
//  Result = (ones - zeros) >>> 1 = ones - STREAM_LEN/2, saturated to the
//  signed range [-2**(BIN_WIDTH-1), 2**(BIN_WIDTH-1)-1]. y_bin is two's
//  complement.
//  STOB_BIPOLAR_EN undefined: unipolar ones count, as above. No port or
//  timing difference between the two builds.
// TESTING  (BIN_WIDTH=10, STREAM_LEN=1024)
//  1. reset; start=1 one cycle, bit_in=0 throughout -> done after exactly
//     1024 clocks; y_bin=0 (bipolar: 10'h200 = -512).
//  2. bit_in=1 throughout -> ones=1024 saturates: y_bin=10'h3FF
//     (bipolar: +512 saturates to 10'h1FF = 511).
//  3. bit_in alternating 1,0 -> y_bin=512 (bipolar: 0); 3 ones in 4 -> 768
//     (bipolar: 256).
//  4. start held high, 3 runs -> done pulses 1025 clocks apart, one cycle
//     wide; busy never high with done.
//  5. reset asserted at COUNT cycle 500 -> no done, y_bin=0, busy=0.
//     Fresh start with all ones -> y_bin=10'h3FF.
//  6. start toggled during COUNT -> no restart; done timing is unchanged
//     from the first start.

Source files
------------

// File: rtl/stob_counter_if.sv
// Handshake/result bundle between the stob_counter and its controller.
// The controller (master) drives start and the stochastic bit; the counter
// (slave) returns the binary result, the done pulse and the busy flag.
interface stob_counter_if #(
  parameter int BIN_WIDTH = 10
);
  logic                 start;
  logic                 bit_in;
  logic [BIN_WIDTH-1:0] y_bin;
  logic                 done;
  logic                 busy;

  modport master (
    output start,
    output bit_in,
    input  y_bin,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  bit_in,
    output y_bin,
    output done,
    output busy
  );
endinterface

// File: rtl/stob_counter.sv
// Stochastic-to-binary converter.
// On start, samples STREAM_LEN bits of the serial bitstream and returns a
// BIN_WIDTH-bit result with a one-cycle done pulse.
// Build option STOB_BIPOLAR_EN: when defined, the accumulator counts up on a
// one and down on a zero, and the result is the signed value
// (ones - zeros) / 2 saturated to the BIN_WIDTH two's-complement range.
// When undefined, the result is the unipolar ones count saturated to
// 2**BIN_WIDTH-1. Ports and timing are identical in both builds.
module stob_counter #(
  parameter int BIN_WIDTH  = 10,
  parameter int STREAM_LEN = 1024
) (
  input  logic          clk,
  input  logic          reset,
  stob_counter_if.slave bus
);

  localparam int            CW       = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(STREAM_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BIN_WIDTH-1:0] y_q, y_d;
  logic                 done_q, done_d;
  logic [BIN_WIDTH-1:0] result_fin;

`ifdef STOB_BIPOLAR_EN
  // Up/down accumulator: two extra bits keep +/-STREAM_LEN representable.
  localparam int                   AW      = BIN_WIDTH + 2;
  localparam logic signed [AW-1:0] STEP_UP = 1;
  localparam logic signed [AW-1:0] STEP_DN = -1;
  localparam logic signed [AW-1:0] SMAX    = AW'((2 ** (BIN_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN    = ~SMAX;

  logic signed [AW-1:0] acc_q, acc_d, acc_fin, acc_half;

  // Fold in the current bit, halve (ones-zeros is always even) and saturate.
  always_comb begin
    acc_fin  = acc_q + (bus.bit_in ? STEP_UP : STEP_DN);
    acc_half = acc_fin >>> 1;
    if (acc_half > SMAX) begin
      result_fin = SMAX[BIN_WIDTH-1:0];
    end else if (acc_half < SMIN) begin
      result_fin = SMIN[BIN_WIDTH-1:0];
    end else begin
      result_fin = acc_half[BIN_WIDTH-1:0];
    end
  end
`else
  // Ones accumulator: one extra bit so a full stream of ones never wraps.
  localparam int            AW   = BIN_WIDTH + 1;
  localparam logic [AW-1:0] UMAX = {1'b0, {BIN_WIDTH{1'b1}}};

  logic [AW-1:0] acc_q, acc_d, acc_fin;

  // Fold in the current bit and clamp the count to the result width.
  always_comb begin
    acc_fin = acc_q + {{(AW - 1){1'b0}}, bus.bit_in};
    if (acc_fin > UMAX) begin
      result_fin = {BIN_WIDTH{1'b1}};
    end else begin
      result_fin = acc_fin[BIN_WIDTH-1:0];
    end
  end
`endif

  // State, counters and result registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start is only looked at in IDLE, the last bit closes the run.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COUNT;
          cyc_d   = '0;
          acc_d   = '0;
        end
      end
      COUNT: begin
        cyc_d = cyc_q + 1'b1;
        acc_d = acc_fin;
        if (cyc_q == LAST_CYC) begin
          state_d = IDLE;
          cyc_d   = '0;
          y_d     = result_fin;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.y_bin = y_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == COUNT);

endmodule
